// File: rtl/univ_lim_counter.sv
// Up/down counter with run-time inclusive limit, programmable step, wrap or
// saturate at the bounds, a registered boundary-event pulse and a sticky overflow.
module univ_lim_counter #(
    parameter int unsigned N    = 8,
    parameter int unsigned S    = 4,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         syn_clr,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         en,
    input  logic         up,
    input  logic [S-1:0] step,
    input  logic [N-1:0] lim,
    input  logic         sat,
    input  logic         clr_ovf,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap_tick,
    output logic         ovf
);

    logic [N-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         ovf_q, ovf_d;
    logic [N-1:0] step_ext;
    logic [N:0]   sum;
    logic         bound_evt;

    assign step_ext = N'(step);
    // Sum kept one bit wider so an overshoot past lim is never lost to truncation.
    assign sum      = {1'b0, cnt_q} + {1'b0, step_ext};

    always_comb begin
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        ovf_d     = ovf_q;
        bound_evt = 1'b0;
        if (syn_clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (load) begin
                cnt_d = (d > lim) ? lim : d;
            end else if (en && (step_ext != '0)) begin
                if (up) begin
                    if (sum <= {1'b0, lim}) begin
                        cnt_d = sum[N-1:0];
                    end else begin
                        bound_evt = 1'b1;
                        cnt_d     = sat ? lim : '0;
                    end
                end else begin
                    if (cnt_q >= step_ext) begin
                        cnt_d = cnt_q - step_ext;
                    end else begin
                        bound_evt = 1'b1;
                        cnt_d     = sat ? '0 : lim;
                    end
                end
            end
            wrap_d = bound_evt;
            ovf_d  = bound_evt | (ovf_q & ~clr_ovf);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= INIT;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q         = cnt_q;
    assign wrap_tick = wrap_q;
    assign ovf       = ovf_q;
    assign max_tick  = (cnt_q == lim);
    assign min_tick  = (cnt_q == '0);

endmodule

// File: tb/tb_univ_lim_counter.sv
// Directed self-checking bench for univ_lim_counter (N=4, S=4, INIT=3).
module tb_univ_lim_counter;

    localparam int unsigned N = 4;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         syn_clr = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] d = '0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic [S-1:0] step = '0;
    logic [N-1:0] lim = 4'd9;
    logic         sat = 1'b0;
    logic         clr_ovf = 1'b0;
    logic [N-1:0] q;
    logic         max_tick, min_tick, wrap_tick, ovf;

    int n_assert = 0;
    int n_fail   = 0;

    univ_lim_counter #(.N(N), .S(S), .INIT(4'd3)) dut (
        .clk(clk), .reset_n(reset_n), .syn_clr(syn_clr), .load(load), .d(d),
        .en(en), .up(up), .step(step), .lim(lim), .sat(sat), .clr_ovf(clr_ovf),
        .q(q), .max_tick(max_tick), .min_tick(min_tick),
        .wrap_tick(wrap_tick), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [N-1:0] eq, input logic ew, input logic eo);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".wrap"}, 32'(wrap_tick), 32'(ew));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        // reset
        #1 reset_n = 1'b0;
        #1 st("rst", 4'd3, 1'b0, 1'b0);
        chk("rst.min", 32'(min_tick), 32'd0);
        chk("rst.max", 32'(max_tick), 32'd0);
        #5 reset_n = 1'b1;
        tick();
        st("hold", 4'd3, 1'b0, 1'b0);

        // up, wrap, step=1
        load = 1'b1; d = 4'd8; tick();
        st("ld8", 4'd8, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd1; sat = 1'b0;
        tick();
        st("upw9", 4'd9, 1'b0, 1'b0);
        chk("upw9.max", 32'(max_tick), 32'd1);
        tick();
        st("upw0", 4'd0, 1'b1, 1'b1);
        chk("upw0.min", 32'(min_tick), 32'd1);
        en = 1'b0; tick();
        st("upw_idle", 4'd0, 1'b0, 1'b1);

        // up, saturate, step=3
        load = 1'b1; d = 4'd8; tick();
        st("ld8b", 4'd8, 1'b0, 1'b1);
        load = 1'b0; clr_ovf = 1'b1; tick();
        st("clrovf", 4'd8, 1'b0, 1'b0);
        clr_ovf = 1'b0; en = 1'b1; sat = 1'b1; step = 4'd3; tick();
        st("sat1", 4'd9, 1'b1, 1'b1);
        tick();
        st("sat2", 4'd9, 1'b1, 1'b1);
        clr_ovf = 1'b1; tick();
        st("sat_clr_race", 4'd9, 1'b1, 1'b1);
        en = 1'b0; tick();
        st("sat_clr", 4'd9, 1'b0, 1'b0);
        clr_ovf = 1'b0;

        // down, wrap, step=2
        load = 1'b1; d = 4'd1; sat = 1'b0; tick();
        st("ld1", 4'd1, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b0; step = 4'd2; tick();
        st("dnw", 4'd9, 1'b1, 1'b1);
        tick();
        st("dn7", 4'd7, 1'b0, 1'b1);
        en = 1'b0; load = 1'b1; d = 4'd0; tick();
        load = 1'b0; en = 1'b1; step = 4'd0; tick();
        st("step0", 4'd0, 1'b0, 1'b1);
        sat = 1'b1; step = 4'd2; tick();
        st("dnsat", 4'd0, 1'b1, 1'b1);

        // load clamp and limit change
        en = 1'b0; sat = 1'b0; load = 1'b1; d = 4'd12; tick();
        st("clamp", 4'd9, 1'b0, 1'b1);
        load = 1'b0; lim = 4'd5; #1;
        chk("limchg.q", 32'(q), 32'd9);
        chk("limchg.max", 32'(max_tick), 32'd0);
        en = 1'b1; up = 1'b1; step = 4'd1; tick();
        st("limw", 4'd0, 1'b1, 1'b1);
        en = 1'b0; lim = 4'd9; load = 1'b1; d = 4'd12; tick();
        load = 1'b0; lim = 4'd5; sat = 1'b1; en = 1'b1; tick();
        st("lims", 4'd5, 1'b1, 1'b1);
        en = 1'b0; lim = 4'd9; load = 1'b1; d = 4'd9; tick();
        load = 1'b0; lim = 4'd5; en = 1'b1; up = 1'b0; step = 4'd2; tick();
        st("limdn", 4'd7, 1'b0, 1'b1);

        // lim = 0 and q = 0
        en = 1'b0; lim = 4'd0; load = 1'b1; d = 4'd0; tick();
        load = 1'b0;
        chk("lim0.max", 32'(max_tick), 32'd1);
        chk("lim0.min", 32'(min_tick), 32'd1);

        // priority
        lim = 4'd9; syn_clr = 1'b1; load = 1'b1; d = 4'd7; en = 1'b1; up = 1'b1;
        step = 4'd1; sat = 1'b0; tick();
        st("prio_clr", 4'd0, 1'b0, 1'b0);
        syn_clr = 1'b0; tick();
        st("prio_ld", 4'd7, 1'b0, 1'b0);

        // async reset mid-count right after an event
        load = 1'b0; tick(); tick(); tick();
        st("pre_rst", 4'd0, 1'b1, 1'b1);
        #3 reset_n = 1'b0;
        #1 st("async_rst", 4'd3, 1'b0, 1'b0);
        tick();
        st("rst_held", 4'd3, 1'b0, 1'b0);
        #3 reset_n = 1'b1;
        tick();
        st("resume", 4'd4, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_lim_counter.md
# univ_lim_counter

Parametrised successor to the team's universal up/down binary counter. Adds:
- a run-time upper limit
- a programmable step size
- selectable wrap or saturate behaviour at the bounds
- a registered boundary-event pulse and a sticky overflow flag

Used as a timebase and event counter in datapath and control blocks. Several instances may be cascaded through `wrap_tick`.

## Interface
Parameters:
- `N`, 8, counter width in bits.
- `S`, 4, step input width in bits; must satisfy 1 <= S <= N.
- `INIT`, 0, reset value of the count; must fit in N bits.

Ports:
- `clk`, input, 1, rising-edge clock.
- `reset_n`, input, 1, reset; asynchronous, active-low.
- `syn_clr`, input, 1, synchronous clear of count and `ovf`.
- `load`, input, 1, synchronous load of `d`.
- `d`, input, N, load value.
- `en`, input, 1, count enable.
- `up`, input, 1, direction: 1 counts up, 0 counts down.
- `step`, input, S, increment/decrement magnitude.
- `lim`, input, N, inclusive upper bound; count range is 0..`lim`.
- `sat`, input, 1, bound mode: 1 saturates, 0 wraps.
- `clr_ovf`, input, 1, synchronous clear of `ovf` only.
- `q`, output, N, current count, driven directly from the count register.
- `max_tick`, output, 1, combinational; high when `q` == `lim`.
- `min_tick`, output, 1, combinational; high when `q` == 0.
- `wrap_tick`, output, 1, registered one-cycle pulse following a boundary event.
- `ovf`, output, 1, registered sticky flag; set by any boundary event.

## Operation
- Priority per cycle: `syn_clr` > `load` > `en`. With none asserted the count holds.
- `syn_clr`:
  - count <= 0, `ovf` <= 0, `wrap_tick` <= 0.
- `load`:
  - count <= min(`d`, `lim`); a load above the limit is clamped to `lim`.
  - `wrap_tick` and `ovf` are unaffected by the load itself.
- `en` with `up`=1:
  - Compute `q` + `step` in N+1 bits.
  - If the sum <= `lim`: count <= sum.
  - Otherwise a boundary event occurs: `sat`=1 gives count <= `lim`; `sat`=0 gives count <= 0.
- `en` with `up`=0:
  - If `q` >= `step`: count <= `q` - `step`.
  - Otherwise a boundary event occurs: `sat`=1 gives count <= 0; `sat`=0 gives count <= `lim`.
- `step` = 0: the count holds and no boundary event occurs, even at a bound.
- Wrap mode jumps to the opposite bound; it is not modular. The remainder of the step is discarded.
- Boundary event:
  - `wrap_tick` <= 1 for exactly one cycle.
  - `ovf` <= 1.
  - These apply in both modes; a saturating count sitting at `lim` with `up`/`en`/`step`!=0 raises an event every cycle.
- `ovf`:
  - Set on any boundary event.
  - Cleared by `syn_clr`, or by `clr_ovf`.
  - Set wins over `clr_ovf` in the same cycle.
- `lim` change below the current count:
  - No immediate effect on `q`.
  - The next enabled up-step is a boundary event.
  - Down-steps subtract normally, even if the result still exceeds `lim`.
- `max_tick`/`min_tick` compare against the live `lim` and count. `max_tick` and `min_tick` are both high when `lim` = 0 and `q` = 0.
- Arithmetic is unsigned. `step` is zero-extended to N bits. No intermediate result is truncated before comparison.

## Timing
- All state updates on the rising `clk` edge; latency one cycle from inputs to `q`.
- `wrap_tick` is asserted in the cycle in which `q` first shows the post-event value, and deasserts the following cycle unless another event occurs.
- `reset_n` low:
  - Asynchronously forces count = `INIT`, `wrap_tick` = 0, `ovf` = 0, mid-operation included.
  - Deassertion is synchronous to the system; the first count update follows the first `clk` edge with `reset_n` high.
- Combinational outputs (`max_tick`, `min_tick`) settle within the same cycle as `q` or `lim` change.

## Test plan
- Up, wrap, step=1:
  - Stimulus: N=4, `lim`=9, `sat`=0, `step`=1, `up`=1, `en`=1 from `q`=8.
  - Response: `q` goes 9 then 0. `wrap_tick`=1 only in the cycle `q`=0. `ovf`=1 thereafter. `max_tick`=1 at `q`=9.
- Up, saturate, step=3:
  - Stimulus: `lim`=9, `sat`=1, `step`=3 from `q`=8.
  - Response: `q` goes 9 and holds. `wrap_tick` pulses every enabled cycle. `clr_ovf` in the same cycle as an event leaves `ovf`=1.
- Down, wrap, step=2:
  - Stimulus: `lim`=9, `sat`=0, `up`=0, `step`=2 from `q`=1.
  - Response: `q` goes 9 with `wrap_tick` pulse. `step`=0 at `q`=0 holds with no pulse.
- Load clamp and limit change:
  - Stimulus: `load`, `d`=12, `lim`=9.
  - Response: `q`=9.
  - Then: set `lim`=5 and count up.
  - Response: boundary event; `q`=0 (wrap) or 5 (sat).
- Priority:
  - Stimulus: `syn_clr`, `load` and `en` asserted together with `ovf`=1.
  - Response: `q`=0, `ovf`=0.
  - Then: `load` and `en` together.
  - Response: `q`=`d`.
- Reset:
  - Stimulus: `INIT`=3; pull `reset_n` low between clock edges mid-count.
  - Response: `q`=3, `wrap_tick`=0, `ovf`=0 immediately. Counting resumes one edge after release.
